// File: rtl/datapath_bist_if.sv
// Stimulus/response bundle between the BIST driver and the datapath under test.
// The slave side is the BIST block; the master side starts runs and returns z.
interface datapath_bist_if;
    logic        start;
    logic [7:0]  z;
    logic [7:0]  a;
    logic        sel;
    logic        busy;
    logic        done;
    logic [15:0] signature;

    modport master (output start, z, input a, sel, busy, done, signature);
    modport slave  (input start, z, output a, sel, busy, done, signature);
endinterface

// File: rtl/datapath_bist.sv
// BIST driver for the 8-bit datapath: LFSR operands out, MISR-compacted z back in.
// state | meaning
// IDLE  | outputs parked at zero, waiting for start
// RUN   | one LFSR vector per cycle on a/sel
// DRAIN | a/sel parked, waiting for the last results to reach the MISR
// DONE  | signature frozen, done high, start restarts the run
module datapath_bist #(
    parameter int         NUM_VECTORS = 64,
    parameter int         SEL_AFTER   = 4,
    parameter logic [7:0] SEED        = 8'h5A,
    parameter int         LATENCY     = 1
) (
    input logic            clk,
    input logic            reset,
    datapath_bist_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [7:0] SEED_EFF  = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [7:0] LAST_VEC  = 8'(NUM_VECTORS - 1);
    localparam logic [8:0] SEL_START = 9'(SEL_AFTER);
    localparam logic [2:0] DRAIN_CNT = 3'(LATENCY);

    state_t               state;
    logic [7:0]           lfsr;
    logic [7:0]           count;
    logic [2:0]           timer;
    logic                 a_valid;
    logic [LATENCY-1:0]   valid_pipe;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [15:0] misr_next(input logic [15:0] s, input logic [7:0] d);
        return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]} ^ {8'h00, d};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            lfsr          <= 8'h00;
            count         <= 8'h00;
            timer         <= 3'd0;
            a_valid       <= 1'b0;
            valid_pipe    <= '0;
            bus.a         <= 8'h00;
            bus.sel       <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.signature <= 16'h0000;
        end else begin
            // a_valid marks the vector currently on a; the pipe ages it to match z.
            for (int i = LATENCY - 1; i > 0; i--) begin
                valid_pipe[i] <= valid_pipe[i-1];
            end
            valid_pipe[0] <= a_valid;
            if (valid_pipe[LATENCY-1]) begin
                bus.signature <= misr_next(bus.signature, bus.z);
            end

            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        bus.a         <= SEED_EFF;
                        bus.sel       <= (SEL_AFTER == 0);
                        a_valid       <= 1'b1;
                        lfsr          <= lfsr_next(SEED_EFF);
                        count         <= 8'd1;
                        timer         <= DRAIN_CNT;
                        bus.busy      <= 1'b1;
                        bus.done      <= 1'b0;
                        bus.signature <= 16'h0000;
                        state         <= (NUM_VECTORS == 1) ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    bus.a   <= lfsr;
                    lfsr    <= lfsr_next(lfsr);
                    bus.sel <= ({1'b0, count} >= SEL_START);
                    count   <= count + 8'd1;
                    if (count == LAST_VEC) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    bus.a   <= 8'h00;
                    bus.sel <= 1'b0;
                    a_valid <= 1'b0;
                    // The final absorption lands on the same edge that enters DONE.
                    if (timer == 3'd0) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end else begin
                        timer <= timer - 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
